rvc_eot_dumper: RTL and testbench

//  Synthesizable end-of-test memory dumper for rvc_top; the hardware producer of the D_MEM snapshot.

---
 rtl/rvc_eot_dumper.sv | 132 +++++++++++++
 tb/tb_rvc_eot_dumper.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_eot_dumper.sv
// End-of-test D_MEM dumper: on EBREAK, sweeps D_MEM and streams {byte addr, word} to a sink.
// Latency: EBREAK sampled at edge n -> read request in n+1 -> first DumpValid in n+3; 1 word / 3 cycles.
// Backpressure: DumpValid holds with a stable payload until DumpReady; the sweep pauses while stalled.
//
// Ports:
//   Clock, Rst            core clock, asynchronous active-high reset
//   Instruction           instruction executing in the core; EBREAK_OPC triggers the dump
//   DumpRdEn/DumpRdAddr   D_MEM read request (one cycle, REQ state only) and word-aligned byte address
//   DumpRdData            D_MEM read data, valid the cycle after DumpRdEn
//   DumpValid/DumpReady   stream handshake
//   DumpAddr/DumpData     presented word and its byte address
//   DumpLast              presented word is the last D_MEM word
//   DumpDone              dump finished; sticky until reset
module rvc_eot_dumper #(
  parameter logic [31:0] D_MEM_OFFSET = 32'h0000_1000,
  parameter int          MSB_D_MEM    = 11,
  parameter logic [31:0] EBREAK_OPC   = 32'h0010_0073
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  output logic        DumpRdEn,
  output logic [31:0] DumpRdAddr,
  input  logic [31:0] DumpRdData,
  output logic        DumpValid,
  input  logic        DumpReady,
  output logic [31:0] DumpAddr,
  output logic [31:0] DumpData,
  output logic        DumpLast,
  output logic        DumpDone
);

  // Byte address of the final word in D_MEM.
  localparam logic [31:0] LAST_ADDR = D_MEM_OFFSET + (32'd1 << (MSB_D_MEM + 1)) - 32'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_last;
  logic        w_rd_en;
  logic        w_valid;
  logic        w_done;
  logic        w_cap;
  logic        w_adv;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    w_valid = 1'b0;
    w_done  = 1'b0;
    w_cap   = 1'b0;
    w_adv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Instruction == EBREAK_OPC) begin
          w_next = REQ;
        end
      end
      REQ: begin
        w_rd_en = 1'b1;
        w_next  = CAP;
      end
      CAP: begin
        w_cap  = 1'b1;
        w_next = SEND;
      end
      SEND: begin
        w_valid = 1'b1;
        if (DumpReady) begin
          if (r_last) begin
            w_next = DONE;
          end else begin
            // Counter only advances below the last word, so it never wraps.
            w_adv  = 1'b1;
            w_next = REQ;
          end
        end
      end
      DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_cnt  <= D_MEM_OFFSET;
      r_addr <= 32'd0;
      r_data <= 32'd0;
      r_last <= 1'b0;
    end else begin
      if (w_cap) begin
        r_addr <= r_cnt;
        r_data <= DumpRdData;
        r_last <= (r_cnt == LAST_ADDR);
      end
      if (w_adv) begin
        r_cnt <= r_cnt + 32'd4;
      end
    end
  end

  assign DumpRdEn   = w_rd_en;
  assign DumpRdAddr = r_cnt;
  assign DumpValid  = w_valid;
  assign DumpAddr   = r_addr;
  assign DumpData   = r_data;
  assign DumpLast   = r_last;
  assign DumpDone   = w_done;

endmodule

// File: tb/tb_rvc_eot_dumper.sv
// Bench for rvc_eot_dumper: instance 0 uses the default 1024-word D_MEM, instance 1 an 8-word D_MEM.
module tb_rvc_eot_dumper;

  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic [31:0] instr  [2];
  logic        rdy    [2];
  logic        rden   [2];
  logic [31:0] rdaddr [2];
  logic        valid  [2];
  logic [31:0] addr   [2];
  logic [31:0] data   [2];
  logic        last   [2];
  logic        done   [2];
  logic [31:0] rddata0 = 32'd0;
  logic [31:0] rddata1 = 32'd0;

  int checks   = 0;
  int failures = 0;
  int rdcnt [2];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
  } wrd_t;
  wrd_t q0[$];
  wrd_t q1[$];

  typedef struct {
    logic [31:0] instr;
    logic        rdy;
    logic        rden;
    logic [31:0] rdaddr;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    logic        done;
  } vec_t;
  vec_t tv [7];

  always #5 clk = ~clk;

  rvc_eot_dumper dut0 (
    .Clock(clk), .Rst(rst[0]), .Instruction(instr[0]),
    .DumpRdEn(rden[0]), .DumpRdAddr(rdaddr[0]), .DumpRdData(rddata0),
    .DumpValid(valid[0]), .DumpReady(rdy[0]), .DumpAddr(addr[0]),
    .DumpData(data[0]), .DumpLast(last[0]), .DumpDone(done[0])
  );

  rvc_eot_dumper #(.MSB_D_MEM(4)) dut1 (
    .Clock(clk), .Rst(rst[1]), .Instruction(instr[1]),
    .DumpRdEn(rden[1]), .DumpRdAddr(rdaddr[1]), .DumpRdData(rddata1),
    .DumpValid(valid[1]), .DumpReady(rdy[1]), .DumpAddr(addr[1]),
    .DumpData(data[1]), .DumpLast(last[1]), .DumpDone(done[1])
  );

  // D_MEM contents are a fixed function of the word index.
  function automatic logic [31:0] memword(input int k, input logic [31:0] idx);
    if (k == 0) return 32'hA500_0000 | idx;
    return 32'hC300_0000 | (idx << 4);
  endfunction

  // Synchronous-read D_MEM models: data valid one cycle after the request.
  logic [31:0] off0, off1;
  assign off0 = (rdaddr[0] - BASE) >> 2;
  assign off1 = (rdaddr[1] - BASE) >> 2;
  always @(posedge clk) begin
    if (rden[0]) rddata0 <= memword(0, off0);
    if (rden[1]) rddata1 <= memword(1, off1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Advance one clock for instance k, logging accepted words and checking stall stability.
  task automatic cycle(input int k);
    logic stall;
    logic [31:0] sa, sd;
    logic sl;
    wrd_t w;
    stall = valid[k] && !rdy[k];
    sa = addr[k];
    sd = data[k];
    sl = last[k];
    if (valid[k] && rdy[k]) begin
      w.a = addr[k];
      w.d = data[k];
      w.l = last[k];
      if (k == 0) q0.push_back(w);
      else q1.push_back(w);
    end
    @(posedge clk);
    #1;
    if (rden[k]) rdcnt[k]++;
    if (stall) begin
      chk1("stall_valid", valid[k], 1'b1);
      chk("stall_addr", addr[k], sa);
      chk("stall_data", data[k], sd);
      chk1("stall_last", last[k], sl);
    end
  endtask

  task automatic chk_reset(input int k);
    chk1("rst_rden", rden[k], 1'b0);
    chk("rst_rdaddr", rdaddr[k], BASE);
    chk1("rst_valid", valid[k], 1'b0);
    chk("rst_addr", addr[k], 32'd0);
    chk("rst_data", data[k], 32'd0);
    chk1("rst_last", last[k], 1'b0);
    chk1("rst_done", done[k], 1'b0);
  endtask

  task automatic chk_stream(input int k, input int n);
    wrd_t s[$];
    int bad_a, bad_d, nlast;
    if (k == 0) s = q0;
    else s = q1;
    bad_a = 0;
    bad_d = 0;
    nlast = 0;
    chk("stream_len", 32'(s.size()), 32'(n));
    foreach (s[i]) begin
      if (s[i].a !== BASE + 32'(4 * i)) bad_a++;
      if (s[i].d !== memword(k, 32'(i))) bad_d++;
      if (s[i].l) nlast++;
    end
    chk("stream_bad_addr", 32'(bad_a), 32'd0);
    chk("stream_bad_data", 32'(bad_d), 32'd0);
    chk("stream_last_count", 32'(nlast), 32'd1);
    if (s.size() > 0) chk1("stream_last_at_end", s[s.size()-1].l, 1'b1);
  endtask

  task automatic restart1();
    rst[1] = 1'b1;
    cycle(1);
    rst[1] = 1'b0;
    q1.delete();
    rdcnt[1] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int hold;

    // Rows: inputs for one edge, expected outputs just after it (instance 0).
    tv[0] = '{EBRK,  1'b1, 1'b1, 32'h1000, 1'b0, 32'h0000, 32'h0,         1'b0, 1'b0};
    tv[1] = '{32'd0, 1'b1, 1'b0, 32'h1000, 1'b0, 32'h0000, 32'h0,         1'b0, 1'b0};
    tv[2] = '{32'd0, 1'b0, 1'b0, 32'h1000, 1'b1, 32'h1000, 32'hA500_0000, 1'b0, 1'b0};
    tv[3] = '{32'd0, 1'b0, 1'b0, 32'h1000, 1'b1, 32'h1000, 32'hA500_0000, 1'b0, 1'b0};
    tv[4] = '{EBRK,  1'b1, 1'b1, 32'h1004, 1'b0, 32'h1000, 32'hA500_0000, 1'b0, 1'b0};
    tv[5] = '{32'd0, 1'b1, 1'b0, 32'h1004, 1'b0, 32'h1000, 32'hA500_0000, 1'b0, 1'b0};
    tv[6] = '{32'd0, 1'b1, 1'b0, 32'h1004, 1'b1, 32'h1004, 32'hA500_0001, 1'b0, 1'b0};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      instr[k] = 32'd0;
      rdy[k] = 1'b0;
      rdcnt[k] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Trigger timing and first words, table driven.
    for (int i = 0; i < 7; i++) begin
      instr[0] = tv[i].instr;
      rdy[0] = tv[i].rdy;
      cycle(0);
      chk1("tv_rden", rden[0], tv[i].rden);
      chk("tv_rdaddr", rdaddr[0], tv[i].rdaddr);
      chk1("tv_valid", valid[0], tv[i].valid);
      chk("tv_addr", addr[0], tv[i].addr);
      chk("tv_data", data[0], tv[i].data);
      chk1("tv_last", last[0], tv[i].last);
      chk1("tv_done", done[0], tv[i].done);
    end

    // Full sweep of the default D_MEM.
    instr[0] = 32'd0;
    rdy[0] = 1'b1;
    n = 0;
    while (!done[0] && n < 4000) begin
      cycle(0);
      n++;
    end
    chk1("sweep_timeout", done[0], 1'b1);
    chk_stream(0, 1024);
    chk("sweep_rden_count", 32'(rdcnt[0]), 32'd1024);
    chk1("sweep_valid_after", valid[0], 1'b0);

    // Non-trigger instructions on the small instance.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      case (i % 3)
        0: instr[1] = 32'h0000_0073;
        1: instr[1] = 32'h0010_0013;
        default: instr[1] = 32'hxxxx_xxxx;
      endcase
      rdy[1] = 1'b1;
      cycle(1);
      if (rden[1] !== 1'b0 || valid[1] !== 1'b0 || done[1] !== 1'b0) bad++;
    end
    chk("nontrig_bad_cycles", 32'(bad), 32'd0);
    chk("nontrig_rden_count", 32'(rdcnt[1]), 32'd0);

    // Backpressure: random ready, word 3 stalled for 5 cycles.
    restart1();
    instr[1] = EBRK;
    rdy[1] = 1'b0;
    cycle(1);
    instr[1] = 32'd0;
    hold = 0;
    n = 0;
    while (!done[1] && n < 600) begin
      if (valid[1] && addr[1] == 32'h100C && hold < 5) begin
        rdy[1] = 1'b0;
        hold++;
      end else begin
        rdy[1] = 1'($urandom_range(0, 1));
      end
      cycle(1);
      n++;
    end
    chk1("bp_timeout", done[1], 1'b1);
    chk("bp_hold_cycles", 32'(hold), 32'd5);
    chk_stream(1, 8);
    chk("bp_rden_count", 32'(rdcnt[1]), 32'd8);

    // Reset in the middle of the dump.
    restart1();
    instr[1] = EBRK;
    rdy[1] = 1'b1;
    cycle(1);
    instr[1] = 32'd0;
    n = 0;
    while (!(valid[1] && addr[1] == 32'h100C) && n < 100) begin
      cycle(1);
      n++;
    end
    chk("mid_word4_reached", addr[1], 32'h100C);
    rst[1] = 1'b1;
    #1;
    chk_reset(1);
    cycle(1);
    rst[1] = 1'b0;
    q1.delete();
    instr[1] = EBRK;
    cycle(1);
    instr[1] = 32'd0;
    n = 0;
    while (q1.size() == 0 && n < 50) begin
      cycle(1);
      n++;
    end
    chk("mid_restart_words", 32'(q1.size()), 32'd1);
    if (q1.size() > 0) begin
      chk("mid_restart_addr", q1[0].a, BASE);
      chk("mid_restart_data", q1[0].d, memword(1, 32'd0));
    end

    // EBREAK held through REQ/CAP/SEND and into DONE.
    restart1();
    instr[1] = EBRK;
    rdy[1] = 1'b1;
    n = 0;
    while (!done[1] && n < 100) begin
      cycle(1);
      n++;
    end
    chk1("retrig_timeout", done[1], 1'b1);
    for (int i = 0; i < 10; i++) cycle(1);
    chk_stream(1, 8);
    chk("retrig_rden_count", 32'(rdcnt[1]), 32'd8);
    chk1("retrig_done_sticky", done[1], 1'b1);
    chk1("retrig_valid", valid[1], 1'b0);
    chk1("retrig_rden", rden[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
